bus_transfer_sequencer: RTL and testbench

- Control stage directly upstream of the 8-bit Register bank on the shared data bus.
- Accepts one register-transfer request per handshake: a source register or an immediate byte, and a destination mask.
- Drives the registers' bus_enable and load strobes in a fixed, glitch-free sequence, so exactly one driver owns the bus while destinations latch.
- Future microcode/decode logic issues transfers through this block instead of toggling register strobes directly.

---
 rtl/bus_transfer_sequencer.sv | 128 ++++++++++++
 tb/tb_bus_transfer_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_transfer_sequencer.sv
// Sequences one register transfer on the shared 8-bit bus: drive, load, release.
// Exactly one source owns the bus while the destination load strobes fire.
module bus_transfer_sequencer #(
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SEL_W-1:0]    req_src,
    input  logic                req_imm_en,
    input  logic [7:0]          req_imm,
    input  logic [NUM_REGS-1:0] req_dst_mask,
    output logic [NUM_REGS-1:0] bus_enable,
    output logic [NUM_REGS-1:0] load,
    output logic                imm_drive,
    output logic [7:0]          imm_out,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [1:0] {IDLE, DRIVE, LOAD, RELEASE} state_t;

    localparam logic [SEL_W:0] NUM_REGS_W = (SEL_W+1)'(NUM_REGS);

    state_t              state_q;
    logic                req_ready_q;
    logic [NUM_REGS-1:0] bus_enable_q;
    logic [NUM_REGS-1:0] load_q;
    logic [NUM_REGS-1:0] dst_q;
    logic                imm_drive_q;
    logic [7:0]          imm_out_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic accept;
    logic reject;

    function automatic logic [NUM_REGS-1:0] src_onehot(input logic [SEL_W-1:0] s);
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (s == SEL_W'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    assign accept = req_valid && req_ready_q;
    assign reject = (req_dst_mask == '0) ||
                    (!req_imm_en && ({1'b0, req_src} >= NUM_REGS_W));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            bus_enable_q <= '0;
            load_q       <= '0;
            dst_q        <= '0;
            imm_drive_q  <= 1'b0;
            imm_out_q    <= 8'h00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept && reject) begin
                        // Rejected requests never touch the bus; ready drops for the err cycle only.
                        err_q       <= 1'b1;
                        req_ready_q <= 1'b0;
                    end else if (accept) begin
                        state_q     <= DRIVE;
                        busy_q      <= 1'b1;
                        req_ready_q <= 1'b0;
                        dst_q       <= req_dst_mask;
                        if (req_imm_en) begin
                            imm_drive_q <= 1'b1;
                            imm_out_q   <= req_imm;
                        end else begin
                            bus_enable_q <= src_onehot(req_src);
                        end
                    end
                end
                DRIVE: begin
                    // Source has had a full cycle to settle before destinations latch.
                    state_q <= LOAD;
                    load_q  <= dst_q;
                end
                LOAD: begin
                    state_q      <= RELEASE;
                    load_q       <= '0;
                    bus_enable_q <= '0;
                    imm_drive_q  <= 1'b0;
                    done_q       <= 1'b1;
                end
                RELEASE: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    bus_enable_q <= '0;
                    load_q       <= '0;
                    imm_drive_q  <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign bus_enable = bus_enable_q;
    assign load       = load_q;
    assign imm_drive  = imm_drive_q;
    assign imm_out    = imm_out_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Scoreboard bench for bus_transfer_sequencer: directed transfers plus a long request stream.
module tb_bus_transfer_sequencer;

    localparam int NUM_REGS = 4;
    localparam int SEL_W    = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_src = '0;
    logic       req_imm_en = 1'b0;
    logic [7:0] req_imm = '0;
    logic [3:0] req_dst_mask = '0;
    logic [3:0] bus_enable;
    logic [3:0] load;
    logic       imm_drive;
    logic [7:0] imm_out;
    logic       busy;
    logic       done;
    logic       err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    bus_transfer_sequencer #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_imm_en(req_imm_en), .req_imm(req_imm),
        .req_dst_mask(req_dst_mask), .bus_enable(bus_enable), .load(load),
        .imm_drive(imm_drive), .imm_out(imm_out), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [3:0] en;
        bit         imm;
        logic [7:0] immv;
        logic [3:0] dst;
        int         acc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [2:0] src, input bit imm_en,
                                   input logic [7:0] imm, input logic [3:0] dst, input int acc);
        exp_t e;
        e.is_err = (dst == 4'b0000) || (!imm_en && (int'(src) >= NUM_REGS));
        e.en     = (imm_en || e.is_err) ? 4'b0000 : (4'b0001 << src);
        e.imm    = imm_en && !e.is_err;
        e.immv   = imm;
        e.dst    = dst;
        e.acc    = acc;
        return e;
    endfunction

    // Presents a request and holds req_valid until the accepting edge has passed.
    task automatic send(input logic [2:0] src, input bit imm_en, input logic [7:0] imm,
                        input logic [3:0] dst, output int acc);
        @(negedge clk);
        req_src = src; req_imm_en = imm_en; req_imm = imm; req_dst_mask = dst; req_valid = 1'b1;
        acc = -1;
        for (int n = 0; n < 16; n++) begin
            if (req_ready) begin
                acc = cyc;
                sb.push_back(model(src, imm_en, imm, dst, cyc));
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: req_ready stayed 0, expected 1 within 16 cycles");
        end else begin
            @(posedge clk);
        end
    endtask

    logic [3:0] prev_en = '0, prev_load = '0, rec_en = '0, rec_load = '0;
    bit         prev_imm = 0, prev_busy = 0, rec_imm = 0, post_done = 0, post_err = 0;
    logic [7:0] rec_immv = '0, last_imm = '0;
    int         drive_cyc = 0, load_cyc = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            last_imm  = 8'h00;
            post_done = 0;
            post_err  = 0;
        end
        chk("single_driver", 32'(($countones(bus_enable) + imm_drive) <= 1), 1);
        chk("done_err_exclusive", 32'(done && err), 0);
        if (load != 4'b0000) begin
            chk("load_one_cycle", 32'(prev_load == 4'b0000), 1);
            chk("load_after_enable", 32'(prev_en == bus_enable && prev_imm == imm_drive &&
                                         (bus_enable != 4'b0000 || imm_drive)), 1);
            rec_load = load;
            load_cyc = cyc;
        end
        if (busy && !prev_busy) begin
            rec_en    = bus_enable;
            rec_imm   = imm_drive;
            rec_immv  = imm_out;
            drive_cyc = cyc;
        end
        if (post_done) begin
            chk("idle_busy", 32'(busy), 0);
            chk("idle_ready", 32'(req_ready), 1);
            chk("imm_out_retained", 32'(imm_out), 32'(last_imm));
            post_done = 0;
        end
        if (post_err) begin
            chk("ready_after_err", 32'(req_ready), 1);
            post_err = 0;
        end
        if (done || err) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'({done, err}), 0);
            end else begin
                e = sb.pop_front();
                chk("response_kind_err", 32'(err), 32'(e.is_err));
                if (done) begin
                    chk("src_enable", 32'(rec_en), 32'(e.en));
                    chk("imm_drive", 32'(rec_imm), 32'(e.imm));
                    if (e.imm) chk("imm_value", 32'(rec_immv), 32'(e.immv));
                    chk("load_mask", 32'(rec_load), 32'(e.dst));
                    chk("drive_latency", 32'(drive_cyc - e.acc), 1);
                    chk("load_latency", 32'(load_cyc - e.acc), 2);
                    chk("done_latency", 32'(cyc - e.acc), 3);
                    chk("release_enable", 32'({bus_enable, imm_drive, load}), 0);
                    chk("release_busy", 32'(busy), 1);
                    if (e.imm) last_imm = e.immv;
                    post_done = 1;
                end else begin
                    chk("err_latency", 32'(cyc - e.acc), 1);
                    chk("err_no_strobes", 32'({bus_enable, imm_drive, load, busy}), 0);
                    chk("err_ready", 32'(req_ready), 0);
                    post_err = 1;
                end
            end
        end
        prev_en   = bus_enable;
        prev_load = load;
        prev_imm  = imm_drive;
        prev_busy = busy;
    end

    initial begin
        int acc, acc2;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_strobes", 32'({bus_enable, load, imm_drive}), 0);
        chk("rst_imm_out", 32'(imm_out), 0);
        chk("rst_flags", 32'({busy, done, err}), 0);
        @(negedge clk) reset = 1'b1;

        // Abort a transfer from reg1 while it is driving the bus.
        send(3'd1, 1'b0, 8'h00, 4'b0001, acc);
        @(negedge clk);
        chk("drive_reg1", 32'(bus_enable), 32'(4'b0010));
        #2 reset = 1'b0;
        #1;
        chk("abort_strobes", 32'({bus_enable, load, imm_drive}), 0);
        chk("abort_flags", 32'({busy, done}), 0);
        chk("abort_ready", 32'(req_ready), 1);
        sb.delete();
        @(negedge clk);
        chk("abort_no_done", 32'(done), 0);
        @(negedge clk);
        reset = 1'b1;
        req_src = 3'd3; req_imm_en = 1'b0; req_imm = 8'h00; req_dst_mask = 4'b1000; req_valid = 1'b1;
        sb.push_back(model(3'd3, 1'b0, 8'h00, 4'b1000, cyc));
        @(posedge clk);
        #1 chk("first_edge_accept", 32'(busy), 1);

        send(3'd2, 1'b0, 8'h00, 4'b0001, acc);
        send(3'd0, 1'b1, 8'hA5, 4'b1010, acc);
        send(3'd0, 1'b0, 8'h00, 4'b0000, acc);
        send(3'd5, 1'b0, 8'h00, 4'b0001, acc);
        send(3'd1, 1'b0, 8'h00, 4'b0100, acc);
        send(3'd0, 1'b1, 8'h3C, 4'b0011, acc2);
        chk("b2b_spacing", 32'(acc2 - acc), 4);

        for (int i = 0; i < 1000; i++) begin
            send(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), acc);
        end
        @(negedge clk) req_valid = 1'b0;

        for (int n = 0; n < 20; n++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_pending", 32'(sb.size()), 0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
